// File: rtl/dmem_responder.sv
// Word-addressed data-memory slave with valid/ready request/response
// handshakes, configurable access latency and misalign/range error flagging.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_gap;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic          w_accept;
  logic          w_enter;
  logic          w_hs;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [31:0]   w_wdata;
  logic [31:0]   w_off;
  logic          w_bad;
  logic [AW-1:0] w_idx;

  // r_gap keeps the port closed for one cycle after each response handshake
  assign req_ready = (r_state == S_IDLE) & reset & ~r_gap;
  assign w_accept  = req_valid & req_ready;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
  assign w_hs      = rsp_valid & rsp_ready;

  // With LATENCY=1 the access resolves on the accept edge itself
  assign w_we    = (r_state == S_IDLE) ? req_we    : r_we;
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_off = w_addr - BASE_ADDR;
  assign w_bad = (w_off[1:0] != 2'b00) | (w_off >= LIMIT);
  assign w_idx = w_off[AW+1:2];

  always_comb begin
    w_next  = r_state;
    w_enter = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_next  = S_RESP;
            w_enter = 1'b1;
          end else begin
            w_next = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next  = S_RESP;
          w_enter = 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_gap   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gap   <= w_hs;
      if (w_accept) begin
        r_cnt   <= CNT_INIT;
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter) begin
        r_err   <= w_bad;
        r_rdata <= (w_we | w_bad) ? 32'd0 : r_mem[w_idx];
      end else if (w_hs) begin
        r_err   <= 1'b0;
        r_rdata <= 32'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter & w_we & ~w_bad) r_mem[w_idx] <= w_wdata;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 instance driven from a vector
// table plus stall/reset sequences, and a LATENCY=1 back-to-back instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic        a_req_valid, a_req_ready, a_req_we;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_rsp_rdata;

  logic        b_req_valid, b_req_ready, b_req_we;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_rdata;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .LATENCY(2),
    .BASE_ADDR(32'h0)
  ) u_a (
    .clk(clk),
    .reset(rst_n),
    .req_valid(a_req_valid),
    .req_ready(a_req_ready),
    .req_we(a_req_we),
    .req_addr(a_req_addr),
    .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid),
    .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err)
  );

  dmem_responder #(
    .DEPTH_WORDS(16),
    .LATENCY(1),
    .BASE_ADDR(32'h1000)
  ) u_b (
    .clk(clk),
    .reset(rst_n),
    .req_valid(b_req_valid),
    .req_ready(b_req_ready),
    .req_we(b_req_we),
    .req_addr(b_req_addr),
    .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid),
    .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
  } rsp_t;

  rsp_t q_a[$];
  rsp_t q_b[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Issue one request on instance A; returns at the negedge where the
  // response is first visible. With hold=0 the response is taken at once.
  task automatic a_xact(input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] exp_rd,
                        input logic exp_err, input bit hold);
    rsp_t e;
    int   n;
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_we    = we;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    a_rsp_ready = !hold;
    n = 0;
    while (!a_req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_req_ready_wait", a_req_ready, 1);
    e.rd  = exp_rd;
    e.err = exp_err;
    q_a.push_back(e);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    n = 1;
    while (!a_rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("a_latency", 32'(n), 32'd2);
    e = q_a.pop_front();
    chk("a_rdata", a_rsp_rdata, e.rd);
    chk("a_err", a_rsp_err, e.err);
    if (!hold) begin
      @(negedge clk);
      chk("a_rsp_drop", a_rsp_valid, 0);
      chk("a_ready_gap", a_req_ready, 0);
      @(negedge clk);
      chk("a_ready_back", a_req_ready, 1);
    end
  endtask

  vec_t        tbl[16];
  vec_t        bl[10];
  logic [31:0] mb[16];

  initial begin
    rsp_t e;
    int   k;
    int   lastacc;
    int   expv;
    logic berr;
    logic [31:0] boff;

    tbl[0]  = '{1'b1, 32'd100,        32'd25,        32'd0,        1'b0};
    tbl[1]  = '{1'b0, 32'd100,        32'd0,         32'd25,       1'b0};
    tbl[2]  = '{1'b1, 32'd8,          32'd3,         32'd0,        1'b0};
    tbl[3]  = '{1'b1, 32'h20,         32'hA5A5A5A5,  32'd0,        1'b0};
    tbl[4]  = '{1'b0, 32'h62,         32'd0,         32'd0,        1'b1};
    tbl[5]  = '{1'b1, 32'h22,         32'd7,         32'd0,        1'b1};
    tbl[6]  = '{1'b0, 32'h20,         32'd0,         32'hA5A5A5A5, 1'b0};
    tbl[7]  = '{1'b1, 32'h102,        32'd7,         32'd0,        1'b1};
    tbl[8]  = '{1'b0, 32'd256,        32'd0,         32'd0,        1'b1};
    tbl[9]  = '{1'b1, 32'd252,        32'hCAFE0001,  32'd0,        1'b0};
    tbl[10] = '{1'b0, 32'd252,        32'd0,         32'hCAFE0001, 1'b0};
    tbl[11] = '{1'b1, 32'd0,          32'h12345678,  32'd0,        1'b0};
    tbl[12] = '{1'b0, 32'd0,          32'd0,         32'h12345678, 1'b0};
    tbl[13] = '{1'b0, 32'hFFFFFFFC,   32'd0,         32'd0,        1'b1};
    tbl[14] = '{1'b0, 32'd8,          32'd0,         32'd3,        1'b0};
    tbl[15] = '{1'b0, 32'h103,        32'd0,         32'd0,        1'b1};

    bl[0] = '{1'b1, 32'h1000, 32'h11, 32'd0, 1'b0};
    bl[1] = '{1'b1, 32'h1004, 32'h22, 32'd0, 1'b0};
    bl[2] = '{1'b1, 32'h103C, 32'h33, 32'd0, 1'b0};
    bl[3] = '{1'b0, 32'h1000, 32'd0,  32'd0, 1'b0};
    bl[4] = '{1'b0, 32'h1004, 32'd0,  32'd0, 1'b0};
    bl[5] = '{1'b0, 32'h103C, 32'd0,  32'd0, 1'b0};
    bl[6] = '{1'b0, 32'h1040, 32'd0,  32'd0, 1'b0};
    bl[7] = '{1'b0, 32'h0FFC, 32'd0,  32'd0, 1'b0};
    bl[8] = '{1'b1, 32'h1001, 32'h99, 32'd0, 1'b0};
    bl[9] = '{1'b0, 32'h1000, 32'd0,  32'd0, 1'b0};

    rst_n       = 1'b0;
    a_req_valid = 1'b0;
    a_req_we    = 1'b0;
    a_req_addr  = 32'd0;
    a_req_wdata = 32'd0;
    a_rsp_ready = 1'b0;
    b_req_valid = 1'b0;
    b_req_we    = 1'b0;
    b_req_addr  = 32'd0;
    b_req_wdata = 32'd0;
    b_rsp_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_a_req_ready", a_req_ready, 0);
    chk("rst_a_rsp_valid", a_rsp_valid, 0);
    chk("rst_a_rdata", a_rsp_rdata, 0);
    chk("rst_a_err", a_rsp_err, 0);
    chk("rst_b_req_ready", b_req_ready, 0);
    chk("rst_b_rsp_valid", b_rsp_valid, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_a_req_ready", a_req_ready, 1);
    chk("rel_b_req_ready", b_req_ready, 1);

    for (int i = 0; i < 16; i++) begin
      a_xact(tbl[i].we, tbl[i].addr, tbl[i].wdata,
             tbl[i].exp_rd, tbl[i].exp_err, 1'b0);
    end

    // response stalled five cycles while the request side thrashes
    a_xact(1'b0, 32'd100, 32'd0, 32'd25, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      a_req_valid = 1'b1;
      a_req_we    = 1'b1;
      a_req_addr  = (i % 2 == 0) ? 32'd100 : 32'd8;
      a_req_wdata = 32'hBAD0 + 32'(i);
      #1;
      chk("stall_valid", a_rsp_valid, 1);
      chk("stall_rdata", a_rsp_rdata, 32'd25);
      chk("stall_err", a_rsp_err, 0);
      chk("stall_req_ready", a_req_ready, 0);
      @(negedge clk);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_release", a_rsp_valid, 0);
    a_xact(1'b0, 32'd100, 32'd0, 32'd25, 1'b0, 1'b0);
    a_xact(1'b0, 32'd8, 32'd0, 32'd3, 1'b0, 1'b0);

    // reset while a store waits: must never land
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_we    = 1'b1;
    a_req_addr  = 32'd8;
    a_req_wdata = 32'hDEADBEEF;
    a_rsp_ready = 1'b1;
    chk("wrst_ready", a_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    a_req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("wrst_req_ready", a_req_ready, 0);
    chk("wrst_rsp_valid", a_rsp_valid, 0);
    chk("wrst_rdata", a_rsp_rdata, 0);
    chk("wrst_err", a_rsp_err, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("wrst_rel_ready", a_req_ready, 1);
    a_xact(1'b0, 32'd8, 32'd0, 32'd3, 1'b0, 1'b0);

    // reset while a load response is held
    a_xact(1'b0, 32'd252, 32'd0, 32'hCAFE0001, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rrst_rsp_valid", a_rsp_valid, 0);
    chk("rrst_rdata", a_rsp_rdata, 0);
    chk("rrst_err", a_rsp_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    a_rsp_ready = 1'b1;
    #1;
    chk("rrst_rel_ready", a_req_ready, 1);

    // LATENCY=1 instance, back-to-back with rsp_ready tied high
    b_rsp_ready = 1'b1;
    k       = 0;
    lastacc = -1;
    expv    = -1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c == expv) chk("b_valid_next", b_rsp_valid, 1);
      if (b_rsp_valid) begin
        if (q_b.size() == 0) begin
          chk("b_spurious_rsp", b_rsp_valid, 0);
        end else begin
          e = q_b.pop_front();
          chk("b_rdata", b_rsp_rdata, e.rd);
          chk("b_err", b_rsp_err, e.err);
        end
      end
      if (k < 10) begin
        b_req_valid = 1'b1;
        b_req_we    = bl[k].we;
        b_req_addr  = bl[k].addr;
        b_req_wdata = bl[k].wdata;
      end else begin
        b_req_valid = 1'b0;
      end
      if (b_req_valid && b_req_ready) begin
        boff = bl[k].addr - 32'h1000;
        berr = (boff[1:0] != 2'b00) || (boff >= 32'd64);
        if (bl[k].we && !berr) mb[boff[5:2]] = bl[k].wdata;
        e.err = berr;
        e.rd  = (bl[k].we || berr) ? 32'd0 : mb[boff[5:2]];
        q_b.push_back(e);
        if (lastacc >= 0) chk("b_spacing", 32'(c - lastacc), 32'd3);
        lastacc = c;
        expv    = c + 1;
        k++;
      end
      if (k == 10 && q_b.size() == 0 && c > expv) break;
    end
    chk("b_all_issued", 32'(k), 32'd10);
    chk("b_all_answered", 32'(q_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
